// File: rtl/sci_ctrl_pkg.sv
// sci_sequencer shared types: FSM states, instruction classes,
// field positions and the decoded datapath bundle.
package sci_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WAIT_EXT,
    WRITE,
    RETIRE,
    HALTED
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_NOP  = 2'b10,
    CLS_HALT = 2'b11
  } class_t;

  localparam int OP_LSB  = 28;
  localparam int CLS_LSB = 26;
  localparam int WR_LSB  = 21;
  localparam int RD_LSB  = 16;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [3:0]  opCode;
    logic [4:0]  wrReg;
    logic [4:0]  rdReg1;
    logic [15:0] imme;
  } dp_t;

  function automatic logic [15:0] satInc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sci_sequencer_if.sv
// sci_sequencer_if: fetch, external-load and datapath control bundle.
// master = sequencer, slave = memory/data source/datapath side.
interface sci_sequencer_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          start;
  logic [AW-1:0] pc_base;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_data;
  logic          ext_ready;
  logic          ext_valid;
  logic [DW-1:0] ext_data;
  logic          wr_enable;
  logic [4:0]    wr_reg;
  logic [4:0]    rd_reg1;
  logic [15:0]   imme;
  logic [3:0]    op_code;
  logic          sel_ch;
  logic [DW-1:0] sel_data;
  logic          busy;
  logic          halted;
  logic [15:0]   instr_count;

  modport master (
    input  start, pc_base,
    input  imem_ack, imem_data,
    input  ext_valid, ext_data,
    output imem_req, imem_addr,
    output ext_ready,
    output wr_enable, wr_reg, rd_reg1,
    output imme, op_code,
    output sel_ch, sel_data,
    output busy, halted, instr_count
  );

  modport slave (
    output start, pc_base,
    output imem_ack, imem_data,
    output ext_valid, ext_data,
    input  imem_req, imem_addr,
    input  ext_ready,
    input  wr_enable, wr_reg, rd_reg1,
    input  imme, op_code,
    input  sel_ch, sel_data,
    input  busy, halted, instr_count
  );
endinterface

// File: rtl/sci_decode.sv
// sci_decode: splits the instruction register into datapath
// fields and one-hot class flags (HALT is the remaining case).
module sci_decode
  import sci_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dp_t         dp,
  output logic        isAlu,
  output logic        isLoad,
  output logic        isNop
);

  class_t cls;

  assign cls = class_t'(ir[CLS_LSB +: 2]);

  assign dp = '{
    opCode: ir[OP_LSB +: 4],
    wrReg:  ir[WR_LSB +: 5],
    rdReg1: ir[RD_LSB +: 5],
    imme:   ir[IMM_LSB +: 16]
  };

  assign isAlu  = (cls == CLS_ALU);
  assign isLoad = (cls == CLS_LOAD);
  assign isNop  = (cls == CLS_NOP);

endmodule

// File: rtl/sci_sequencer.sv
// sci_sequencer: multi-cycle fetch/decode/write controller for
// the register-file/ALU/write-back-mux datapath.
module sci_sequencer
  import sci_ctrl_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  sci_sequencer_if.master bus
);

  state_t        state;
  logic [AW-1:0] pc;
  logic [31:0]   ir;
  logic [DW-1:0] selData;
  logic [15:0]   count;
  logic          imemReq;
  logic          extReady;
  logic          wrEnable;
  logic          selCh;
  logic          busy;
  logic          halted;
  logic          dpActive;
  dp_t           dp;
  logic          isAlu;
  logic          isLoad;
  logic          isNop;
  logic          wrOk;

  sci_decode u_decode (
    .ir     (ir),
    .dp     (dp),
    .isAlu  (isAlu),
    .isLoad (isLoad),
    .isNop  (isNop)
  );

  assign wrOk = !(ZERO_REG_RO && dp.wrReg == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      selData  <= '0;
      count    <= '0;
      imemReq  <= 1'b0;
      extReady <= 1'b0;
      wrEnable <= 1'b0;
      selCh    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      dpActive <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (bus.start) begin
            state   <= FETCH;
            pc      <= bus.pc_base;
            count   <= '0;
            imemReq <= 1'b1;
            busy    <= 1'b1;
            halted  <= 1'b0;
          end
        end
        FETCH: begin
          if (bus.imem_ack) begin
            ir       <= bus.imem_data;
            imemReq  <= 1'b0;
            dpActive <= 1'b1;
            state    <= DECODE;
          end
        end
        DECODE: begin
          unique case (1'b1)
            isAlu: begin
              state    <= WRITE;
              wrEnable <= wrOk;
              selCh    <= 1'b0;
            end
            isLoad: begin
              state    <= WAIT_EXT;
              extReady <= 1'b1;
            end
            isNop: begin
              state    <= RETIRE;
              dpActive <= 1'b0;
            end
            default: begin
              state    <= HALTED;
              dpActive <= 1'b0;
              busy     <= 1'b0;
              halted   <= 1'b1;
              count    <= satInc(count);
            end
          endcase
        end
        WAIT_EXT: begin
          if (bus.ext_valid) begin
            selData  <= bus.ext_data;
            selCh    <= 1'b1;
            wrEnable <= wrOk;
            extReady <= 1'b0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          wrEnable <= 1'b0;
          selCh    <= 1'b0;
          dpActive <= 1'b0;
          state    <= RETIRE;
        end
        RETIRE: begin
          pc      <= pc + AW'(1);
          count   <= satInc(count);
          imemReq <= 1'b1;
          state   <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath fields are only presented from DECODE through WRITE.
  assign bus.imem_req    = imemReq;
  assign bus.imem_addr   = pc;
  assign bus.ext_ready   = extReady;
  assign bus.wr_enable   = wrEnable;
  assign bus.wr_reg      = dpActive ? dp.wrReg : 5'd0;
  assign bus.rd_reg1     = dpActive ? dp.rdReg1 : 5'd0;
  assign bus.imme        = dpActive ? dp.imme : 16'd0;
  assign bus.op_code     = dpActive ? dp.opCode : 4'd0;
  assign bus.sel_ch      = selCh;
  assign bus.sel_data    = selData;
  assign bus.busy        = busy;
  assign bus.halted      = halted;
  assign bus.instr_count = count;

endmodule

// File: tb/tb_sci_sequencer.sv
// tb_sci_sequencer: directed scenarios for sci_sequencer with an
// instruction-memory responder and a write-pulse monitor.
module tb_sci_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sci_sequencer_if bus ();

  sci_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [256];
  int          ackDelay = 0;
  int          waitCnt = 0;
  logic [7:0]  fetchLog [$];

  int          wrCount = 0;
  logic [4:0]  lastWrReg;
  logic [4:0]  lastRd;
  logic [15:0] lastImme;
  logic [3:0]  lastOp;
  logic        lastSelCh;
  logic [31:0] lastSelData;

  always @(negedge clk) begin
    if (bus.imem_req) begin
      if (waitCnt >= ackDelay) begin
        bus.imem_ack = 1'b1;
        bus.imem_data = mem[bus.imem_addr];
        fetchLog.push_back(bus.imem_addr);
        waitCnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        waitCnt++;
      end
    end else begin
      bus.imem_ack = 1'b0;
      waitCnt = 0;
    end
  end

  always @(negedge clk) begin
    if (bus.wr_enable) begin
      wrCount++;
      lastWrReg = bus.wr_reg;
      lastRd = bus.rd_reg1;
      lastImme = bus.imme;
      lastOp = bus.op_code;
      lastSelCh = bus.sel_ch;
      lastSelData = bus.sel_data;
    end
  end

  function automatic logic [31:0] ins(
    input logic [3:0] op, input logic [1:0] cls,
    input logic [4:0] wr, input logic [4:0] rd,
    input logic [15:0] imm
  );
    return {op, cls, wr, rd, imm};
  endfunction

  function automatic logic [91:0] outVec();
    return {bus.imem_req, bus.imem_addr, bus.ext_ready,
            bus.wr_enable, bus.wr_reg, bus.rd_reg1, bus.imme,
            bus.op_code, bus.sel_ch, bus.sel_data, bus.busy,
            bus.halted, bus.instr_count};
  endfunction

  task automatic clearLogs();
    wrCount = 0;
    fetchLog.delete();
  endtask

  task automatic startAt(input logic [7:0] a);
    @(negedge clk);
    bus.pc_base = a;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitHalt(input int budget, output int cyc);
    cyc = 0;
    while (!bus.halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    compared++;
    if (bus.halted !== 1'b1) begin
      mismatched++;
      $display("FAIL halt_wait: halted=%b after %0d cycles, want 1",
               bus.halted, cyc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if (outVec() !== '0) begin
      mismatched++;
      $display("FAIL reset_outs: got %h want 0", outVec());
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (outVec() !== '0) begin
      mismatched++;
      $display("FAIL idle_outs: got %h want 0", outVec());
    end
  endtask

  task automatic test_alu();
    int cyc;
    clearLogs();
    ackDelay = 1;
    startAt(8'h10);
    waitHalt(60, cyc);
    compared++;
    if (wrCount !== 1) begin
      mismatched++;
      $display("FAIL alu_wr_pulses: got %0d want 1", wrCount);
    end
    compared++;
    if ({lastWrReg, lastSelCh, lastRd} !== {5'd7, 1'b0, 5'd2}) begin
      mismatched++;
      $display("FAIL alu_wr_fields: got wr=%0d ch=%b rd=%0d want 7 0 2",
               lastWrReg, lastSelCh, lastRd);
    end
    compared++;
    if ({lastImme, lastOp} !== {16'h0005, 4'h3}) begin
      mismatched++;
      $display("FAIL alu_imm_op: got imme=%h op=%h want 0005 3",
               lastImme, lastOp);
    end
    compared++;
    if (fetchLog.size() != 2 || fetchLog[1] !== 8'h11) begin
      mismatched++;
      $display("FAIL alu_next_fetch: got %p want 10,11", fetchLog);
    end
    compared++;
    if (bus.instr_count !== 16'd2) begin
      mismatched++;
      $display("FAIL alu_count: got %0d want 2", bus.instr_count);
    end
    ackDelay = 0;
  endtask

  task automatic test_load();
    int  rdy = 0;
    bit  done = 0;
    int  cyc;
    clearLogs();
    bus.ext_data = 32'h1111_1111;
    bus.ext_valid = 1'b1;
    startAt(8'h50);
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (bus.ext_ready) begin
        rdy++;
        bus.ext_valid = (rdy == 3);
        bus.ext_data = (rdy == 3) ? 32'hDEAD_BEEF : 32'h1111_1111;
      end else if (rdy > 0) begin
        bus.ext_valid = 1'b0;
        done = 1;
        compared++;
        if ({bus.wr_enable, bus.sel_ch, bus.wr_reg} !== {2'b11, 5'd4}) begin
          mismatched++;
          $display("FAIL load_write: got we=%b ch=%b wr=%0d want 1 1 4",
                   bus.wr_enable, bus.sel_ch, bus.wr_reg);
        end
        compared++;
        if (bus.sel_data !== 32'hDEAD_BEEF) begin
          mismatched++;
          $display("FAIL load_data: got %h want deadbeef", bus.sel_data);
        end
      end
    end
    bus.ext_valid = 1'b0;
    compared++;
    if (!done || rdy != 3) begin
      mismatched++;
      $display("FAIL load_ready_cycles: got %0d done=%0d want 3 1",
               rdy, done);
    end
    waitHalt(60, cyc);
    compared++;
    if (wrCount !== 1 || bus.instr_count !== 16'd2) begin
      mismatched++;
      $display("FAIL load_retire: got wr=%0d cnt=%0d want 1 2",
               wrCount, bus.instr_count);
    end
  endtask

  task automatic test_sequence();
    int cyc;
    bit reqSeen = 0;
    clearLogs();
    startAt(8'h20);
    waitHalt(60, cyc);
    compared++;
    if (cyc != 9) begin
      mismatched++;
      $display("FAIL seq_latency: got %0d cycles want 9", cyc);
    end
    compared++;
    if ({bus.instr_count, bus.busy} !== {16'd3, 1'b0}) begin
      mismatched++;
      $display("FAIL seq_halt_state: got cnt=%0d busy=%b want 3 0",
               bus.instr_count, bus.busy);
    end
    compared++;
    if (wrCount !== 1 || lastWrReg !== 5'd9) begin
      mismatched++;
      $display("FAIL seq_write: got n=%0d wr=%0d want 1 9",
               wrCount, lastWrReg);
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.imem_req) reqSeen = 1;
    end
    compared++;
    if (reqSeen) begin
      mismatched++;
      $display("FAIL seq_halt_quiet: got imem_req=1 want 0");
    end
    startAt(8'h20);
    compared++;
    if ({bus.instr_count, bus.imem_addr, bus.imem_req, bus.halted}
        !== {16'd0, 8'h20, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL seq_restart: got cnt=%0d addr=%h req=%b hlt=%b want 0 20 1 0",
               bus.instr_count, bus.imem_addr, bus.imem_req, bus.halted);
    end
    waitHalt(60, cyc);
    compared++;
    if (bus.instr_count !== 16'd3) begin
      mismatched++;
      $display("FAIL seq_rerun_count: got %0d want 3", bus.instr_count);
    end
  endtask

  task automatic test_pc_wrap();
    int cyc;
    clearLogs();
    startAt(8'hFF);
    waitHalt(60, cyc);
    compared++;
    if (fetchLog.size() != 3 || fetchLog[0] !== 8'hFF ||
        fetchLog[1] !== 8'h00 || fetchLog[2] !== 8'h01) begin
      mismatched++;
      $display("FAIL wrap_fetch: got %p want ff,00,01", fetchLog);
    end
    compared++;
    if (wrCount !== 0) begin
      mismatched++;
      $display("FAIL wrap_zero_reg: got %0d pulses want 0", wrCount);
    end
    compared++;
    if (bus.instr_count !== 16'd3) begin
      mismatched++;
      $display("FAIL wrap_count: got %0d want 3", bus.instr_count);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen = 0;
    clearLogs();
    startAt(8'h30);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.ext_ready) seen = 1;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL mid_reach_wait: got ext_ready=0 want 1");
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (outVec() !== '0) begin
      mismatched++;
      $display("FAIL mid_async_clear: got %h want 0", outVec());
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (wrCount !== 0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_no_write: got n=%0d busy=%b want 0 0",
               wrCount, bus.busy);
    end
    startAt(8'h10);
    waitHalt(60, cyc);
    compared++;
    if (wrCount !== 1 || bus.instr_count !== 16'd2) begin
      mismatched++;
      $display("FAIL mid_restart: got n=%0d cnt=%0d want 1 2",
               wrCount, bus.instr_count);
    end
  endtask

  task automatic test_start_busy();
    int cyc;
    bit stable = 1;
    clearLogs();
    ackDelay = 5;
    startAt(8'h40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.imem_addr !== 8'h40 || bus.imem_req !== 1'b1) stable = 0;
      if (i == 0) begin
        bus.pc_base = 8'h80;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    compared++;
    if (!stable) begin
      mismatched++;
      $display("FAIL busy_addr_stable: got unstable want addr 40 req 1");
    end
    waitHalt(100, cyc);
    compared++;
    if (fetchLog.size() != 2 || fetchLog[0] !== 8'h40 ||
        fetchLog[1] !== 8'h41) begin
      mismatched++;
      $display("FAIL busy_start_ignored: got %p want 40,41", fetchLog);
    end
    compared++;
    if (wrCount !== 1 || lastWrReg !== 5'd3 ||
        bus.instr_count !== 16'd2) begin
      mismatched++;
      $display("FAIL busy_result: got n=%0d wr=%0d cnt=%0d want 1 3 2",
               wrCount, lastWrReg, bus.instr_count);
    end
    ackDelay = 0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pc_base = '0;
    bus.ext_valid = 1'b0;
    bus.ext_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = ins(4'h0, 2'b11, 5'd0, 5'd0, 16'h0);
    mem[8'h10] = ins(4'h3, 2'b00, 5'd7, 5'd2, 16'h0005);
    mem[8'h20] = ins(4'h0, 2'b10, 5'd0, 5'd0, 16'h0000);
    mem[8'h21] = ins(4'h5, 2'b00, 5'd9, 5'd1, 16'h1234);
    mem[8'h30] = ins(4'h0, 2'b01, 5'd5, 5'd0, 16'h0000);
    mem[8'h40] = ins(4'h1, 2'b00, 5'd3, 5'd4, 16'h00AA);
    mem[8'h50] = ins(4'h0, 2'b01, 5'd4, 5'd0, 16'h0000);
    mem[8'h80] = ins(4'h9, 2'b00, 5'd12, 5'd1, 16'h0001);
    mem[8'hFF] = ins(4'h0, 2'b10, 5'd0, 5'd0, 16'h0000);
    mem[8'h00] = ins(4'h2, 2'b00, 5'd0, 5'd3, 16'h0007);
    test_reset();
    test_alu();
    test_load();
    test_sequence();
    test_pc_wrap();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
